flat_history_buffer: RTL
========================

# flat_history_buffer

Clocked, parametrised successor to the combinational flattening stage. It captures one `numChannels`-wide word per valid cycle into a `depth`-deep history and presents the history as a single flat array in the established flat ordering. It tracks fill level, raises `out_valid` once the history is fully populated, and supports a synchronous flush. It sits between the per-channel ADC/equalizer sample path and the flat-array consumers (FFE/MLSD checkers, error trackers).

## Interface
- `numChannels`, 16, number of parallel channels per captured word.
- `bitwidth`, 8, bits per sample.
- `depth`, 5, number of words held in history; legal range 2 to 64.
- `is_signed`, 0, when 1, `in_data` and `flat_buffer` are declared signed; storage is otherwise identical.
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `in_data` input `[bitwidth-1:0] x [numChannels-1:0]` — incoming word; channel index is the unpacked dimension.
- `in_valid` input 1 — captures `in_data` on this edge.
- `flush` input 1 — synchronous clear of history and fill level.
- `flat_buffer` output `[bitwidth-1:0] x [numChannels*depth-1:0]` — flattened history.
- `out_valid` output 1 — history holds `depth` valid words.
- `fill_count` output `$clog2(depth+1)` — number of valid words held, saturating at `depth`.

## Operation
- History `hist[ch][d]`, with d=0 newest and d=depth-1 oldest.
- On `in_valid`: `hist[ch][d] <= hist[ch][d-1]` for d≥1, and `hist[ch][0] <= in_data[ch]`. Without `in_valid`, the history holds.
- Flat mapping: `flat_buffer[(depth-1-d)*numChannels + ch] = hist[ch][d]`.
  - The newest word occupies the top `numChannels` entries.
  - The oldest word occupies indices `0..numChannels-1`.
- `fill_count` increments by 1 per `in_valid` and saturates at `depth`.
- `out_valid = (fill_count == depth)`, subject to the output stage below.
- Flush: all `hist` entries become 0 and `fill_count` becomes 0.
- Flush and `in_valid` in the same cycle: the history is cleared, then the new word is loaded at d=0, giving `fill_count=1`. Flush has priority over the shift but does not drop the incoming word.
- Reset has priority over everything. It clears `hist` to 0, `fill_count` to 0 and `out_valid` to 0, and clears the output register when it is compiled in.
- Reset mid-fill discards all partial history. No state survives reset.
- Signedness affects only the declared type. No sign extension or arithmetic is performed.

## Timing
- Reset values: `flat_buffer` all 0, `out_valid` 0, `fill_count` 0.
- Output register not compiled in:
  - A word captured at edge k appears on `flat_buffer` after edge k, with 1-cycle latency from `in_data`.
  - `out_valid` rises after the edge that captures the `depth`-th word.
- `fill_count` is never delayed by the output stage.
- After a flush at edge k, `out_valid` is 0 after edge k, or after edge k+1 when the output register is compiled in.
- `in_valid` may toggle every cycle; there is no back-pressure.
- Once full, continued captures keep `out_valid` high and slide the window.

## Configuration
- Macro `FLAT_HISTORY_BUFFER_OUT_REG_EN`.
- Defined:
  - Adds one register stage on `flat_buffer` and `out_valid`. Latency from `in_data` to `flat_buffer` becomes 2 cycles.
  - The stage updates every cycle, regardless of `in_valid`, and resets to 0.
- Undefined: `flat_buffer` is driven directly from `hist` and `out_valid` directly from `fill_count`.

## Test plan
All scenarios use `numChannels=2`, `bitwidth=8`, `depth=3` unless stated.
- Reset: hold `rst` for 2 cycles with `in_valid=1` → `flat_buffer` all 0, `fill_count=0`, `out_valid=0`.
- Fill and order: capture words {ch0,ch1} = {1,2}, {3,4}, {5,6} on consecutive edges → `flat_buffer[0..5] = 1,2,3,4,5,6`, `fill_count=3`, `out_valid=1` after the third edge, not before.
- Slide and hold:
  - Capture {7,8} → `flat_buffer = 3,4,5,6,7,8`.
  - Then 4 idle cycles → output unchanged, `fill_count` stays 3.
- Flush with capture: when full, assert `flush` and `in_valid` with {9,10} → `flat_buffer = 0,0,0,0,9,10`, `fill_count=1`, `out_valid=0`.
- Signed and reset mid-fill:
  - Set `is_signed=1` and capture {-1,-128} → top entries read 0xFF and 0x80 as -1 and -128.
  - Assert `rst` after 2 captures → everything returns to 0.
- Output register compiled in: repeat the fill-and-order scenario → each `flat_buffer`/`out_valid` change lags the non-register build by exactly 1 cycle, and `fill_count` timing is unchanged.

Source files
------------

// File: rtl/flat_history_buffer_if.sv
// -----------------------------------------------------------------------------
// flat_history_buffer_if
//   Bundles the sample-path and flat-array signals of flat_history_buffer.
//
//   master : drives in_data / in_valid / flush and observes the flat history
//            (sample path, or a testbench)
//   slave  : the history buffer itself
//
//   in_data     [bitwidth-1:0] x [numChannels-1:0]        incoming word
//   in_valid                                               capture strobe
//   flush                                                  synchronous clear
//   flat_buffer [bitwidth-1:0] x [numChannels*depth-1:0]  flattened history
//   out_valid                                              history full
//   fill_count  $clog2(depth+1)                            valid words held
// -----------------------------------------------------------------------------
interface flat_history_buffer_if #(
  parameter int numChannels = 16,
  parameter int bitwidth    = 8,
  parameter int depth       = 5
);
  localparam int CNT_W = $clog2(depth + 1);

  logic [bitwidth-1:0] in_data     [numChannels-1:0];
  logic                in_valid;
  logic                flush;
  logic [bitwidth-1:0] flat_buffer [numChannels*depth-1:0];
  logic                out_valid;
  logic [CNT_W-1:0]    fill_count;

  modport master (
    output in_data, in_valid, flush,
    input  flat_buffer, out_valid, fill_count
  );

  modport slave (
    input  in_data, in_valid, flush,
    output flat_buffer, out_valid, fill_count
  );
endinterface

// File: rtl/flat_history_buffer.sv
// -----------------------------------------------------------------------------
// flat_history_buffer
//   Captures one numChannels-wide word per in_valid cycle into a depth-deep
//   history and presents it as one flat array: the oldest word sits at
//   indices 0..numChannels-1, the newest word in the top numChannels entries.
//   Tracks a saturating fill level and raises out_valid once the history is
//   fully populated. flush clears the history; a word arriving in the same
//   cycle as flush is kept as the first word of the fresh history.
//
//   Ports
//     clk   : single clock, rising edge
//     rst   : synchronous, active-high reset (priority over everything)
//     bus   : flat_history_buffer_if.slave (in_data, in_valid, flush,
//             flat_buffer, out_valid, fill_count)
//
//   Parameters
//     numChannels, bitwidth, depth (2..64), is_signed (0/1). Samples are
//     carried as raw bit patterns; with is_signed=1 consumers read them as
//     two's complement. No arithmetic is performed on them here.
//
//   Configuration
//     FLAT_HISTORY_BUFFER_OUT_REG_EN : when defined, flat_buffer and out_valid
//     pass through one extra register stage (updated every cycle, reset to 0).
//     fill_count is never delayed.
// -----------------------------------------------------------------------------
module flat_history_buffer #(
  parameter int numChannels = 16,
  parameter int bitwidth    = 8,
  parameter int depth       = 5,
  parameter int is_signed   = 0
) (
  input logic                  clk,
  input logic                  rst,
  flat_history_buffer_if.slave bus
);
  localparam int               CNT_W  = $clog2(depth + 1);
  localparam int               FLAT_N = numChannels * depth;
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(depth);

  if (depth < 2 || depth > 64) begin : g_bad_depth
    $error("flat_history_buffer: depth must be within 2..64");
  end
  if (is_signed != 0 && is_signed != 1) begin : g_bad_signed
    $error("flat_history_buffer: is_signed must be 0 or 1");
  end

  // hist_q[ch][d]: d=0 newest, d=depth-1 oldest
  logic [bitwidth-1:0] hist_q [numChannels][depth];
  logic [bitwidth-1:0] hist_d [numChannels][depth];
  logic [CNT_W-1:0]    fill_q, fill_d;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so the shift below reads values already updated in this
  // block and no latch can be inferred.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;

    // Flush clears first; a concurrent capture then lands in the cleared
    // history, so the incoming word is never dropped.
    if (bus.flush) begin
      hist_d = '{default: '{default: '0}};
      fill_d = '0;
    end

    if (bus.in_valid) begin
      for (int ch = 0; ch < numChannels; ch++) begin
        // Walk oldest-to-newest so each slot copies its not-yet-shifted neighbour
        for (int d = depth - 1; d >= 1; d--) begin
          hist_d[ch][d] = hist_d[ch][d-1];
        end
        hist_d[ch][0] = bus.in_data[ch];
      end
      if (fill_d != FULL) begin
        fill_d = fill_d + CNT_W'(1);
      end
    end
  end

  // NOTE: the history is built from flops, not a RAM, so it is reset like any
  // other state: no partial history may survive reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '{default: '{default: '0}};
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  // Flat view: flat[(depth-1-d)*numChannels + ch] = hist[ch][d]
  logic [bitwidth-1:0] flat_d [FLAT_N-1:0];
  logic                out_valid_d;

  always_comb begin
    flat_d = '{default: '0};
    for (int d = 0; d < depth; d++) begin
      for (int ch = 0; ch < numChannels; ch++) begin
        flat_d[(depth - 1 - d) * numChannels + ch] = hist_q[ch][d];
      end
    end
    out_valid_d = (fill_q == FULL);
  end

`ifdef FLAT_HISTORY_BUFFER_OUT_REG_EN
  logic [bitwidth-1:0] flat_q [FLAT_N-1:0];
  logic                out_valid_q;

  // Free-running retiming stage: follows the history every cycle, so after a
  // flush out_valid drops one cycle later than fill_count.
  always_ff @(posedge clk) begin
    if (rst) begin
      flat_q      <= '{default: '0};
      out_valid_q <= 1'b0;
    end else begin
      flat_q      <= flat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.flat_buffer = flat_q;
  assign bus.out_valid   = out_valid_q;
`else
  assign bus.flat_buffer = flat_d;
  assign bus.out_valid   = out_valid_d;
`endif

  assign bus.fill_count = fill_q;

endmodule
